phase_error_detector: RTL and testbench

Digital phase/frequency detector for the ADPLL, sitting directly upstream of the loop filter. Samples the reference clock and the divided DCO feedback clock in the `gen_clk_i` domain and counts `gen_clk_i` cycles between their rising edges. Emits a saturated signed error word with a one-cycle valid strobe; this word feeds the loop filter's `error_i`. Optionally reports lock.

---
 rtl/phase_error_detector_pkg.sv | 34 +++
 rtl/phase_error_detector_if.sv | 13 +
 rtl/phase_error_detector_edge_sync.sv | 30 +++
 rtl/phase_error_detector.sv | 175 +++++++++++++++++
 tb/tb_phase_error_detector.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/phase_error_detector_pkg.sv
// Shared ADPLL definitions: detector FSM states, the default error width
// (shared with the loop filter) and saturating arithmetic helpers.
package adpll_pkg;

  localparam int unsigned ADPLL_ERROR_WIDTH = 32'd8;

  typedef enum logic [1:0] {
    PD_IDLE     = 2'd0,
    PD_REF_LEAD = 2'd1,
    PD_FB_LEAD  = 2'd2
  } pd_state_e;

  // Increment that sticks at max_val instead of wrapping.
  function automatic int unsigned sat_inc(input int unsigned val, input int unsigned max_val);
    int unsigned res;
    if (val >= max_val) begin
      res = max_val;
    end else begin
      res = val + 32'd1;
    end
    return res;
  endfunction

  function automatic int unsigned abs_err(input int val);
    int unsigned res;
    if (val < 32'sd0) begin
      res = -val;
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/phase_error_detector_if.sv
// Output bus of the phase/frequency detector towards the loop filter.
interface phase_error_detector_if #(
  parameter int unsigned ERROR_WIDTH = adpll_pkg::ADPLL_ERROR_WIDTH
);

  logic signed [ERROR_WIDTH-1:0] error_o;
  logic                          valid_o;
  logic                          lock_o;

  modport master (output error_o, output valid_o, output lock_o);
  modport slave  (input  error_o, input  valid_o, input  lock_o);

endinterface

// File: rtl/phase_error_detector_edge_sync.sv
// edge_sync: multi-flop synchronizer followed by a one-cycle rising-edge pulse.
module edge_sync #(
  parameter int unsigned SYNC_STAGES = 32'd2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic pulse_o
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   hist_r;
  logic                   pulse_r;

  // Synchronize, remember the previous synced level, register the rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r  <= {SYNC_STAGES{1'b0}};
      hist_r  <= 1'b0;
      pulse_r <= 1'b0;
    end else begin
      sync_r  <= {sync_r[SYNC_STAGES-2:0], async_i};
      hist_r  <= sync_r[SYNC_STAGES-1];
      pulse_r <= sync_r[SYNC_STAGES-1] & ~hist_r;
    end
  end

  assign pulse_o = pulse_r;

endmodule

// File: rtl/phase_error_detector.sv
// ADPLL phase/frequency detector: counts sampling cycles between ref and fb edges.
// Optional lock detection is compiled in with PHASE_ERROR_LOCK_DETECT_EN.
module phase_error_detector
  import adpll_pkg::*;
#(
  parameter int unsigned ERROR_WIDTH = ADPLL_ERROR_WIDTH,
  parameter int unsigned SYNC_STAGES = 32'd2,
  parameter int unsigned LOCK_THRESH = 32'd2,
  parameter int unsigned LOCK_COUNT  = 32'd16
) (
  input  logic gen_clk_i,
  input  logic reset_n_i,
  input  logic ref_clk_i,
  input  logic fb_clk_i,
  phase_error_detector_if.master pd_if
);

  localparam int unsigned CNT_W   = ERROR_WIDTH - 32'd1;
  localparam int unsigned CNT_MAX = (32'd1 << CNT_W) - 32'd1;

  logic                          ref_pulse_s;
  logic                          fb_pulse_s;
  pd_state_e                     state_r;
  logic [CNT_W-1:0]              cnt_r;
  logic [CNT_W-1:0]              cnt_inc_s;
  logic signed [ERROR_WIDTH-1:0] pos_err_s;
  logic signed [ERROR_WIDTH-1:0] neg_err_s;
  logic signed [ERROR_WIDTH-1:0] max_pos_s;
  logic signed [ERROR_WIDTH-1:0] max_neg_s;
  logic signed [ERROR_WIDTH-1:0] emit_err_s;
  logic                          emit_valid_s;
  logic signed [ERROR_WIDTH-1:0] error_r;
  logic                          valid_r;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
    .clk(gen_clk_i), .rst_n(reset_n_i), .async_i(ref_clk_i), .pulse_o(ref_pulse_s)
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_fb_sync (
    .clk(gen_clk_i), .rst_n(reset_n_i), .async_i(fb_clk_i), .pulse_o(fb_pulse_s)
  );

  // cnt+1 saturated equals the lag in cycles, so one value serves both roles.
  assign cnt_inc_s = CNT_W'(sat_inc(32'(cnt_r), CNT_MAX));
  assign pos_err_s = {1'b0, cnt_inc_s};
  assign neg_err_s = -pos_err_s;
  assign max_pos_s = {1'b0, {CNT_W{1'b1}}};
  assign max_neg_s = -max_pos_s;

  // Decide whether this cycle closes a measurement and with which value.
  always_comb begin
    emit_valid_s = 1'b0;
    emit_err_s   = {ERROR_WIDTH{1'b0}};
    case (state_r)
      PD_IDLE: begin
        if (ref_pulse_s && fb_pulse_s) begin
          emit_valid_s = 1'b1;
          emit_err_s   = {ERROR_WIDTH{1'b0}};
        end else begin
          emit_valid_s = 1'b0;
        end
      end
      PD_REF_LEAD: begin
        if (fb_pulse_s) begin
          emit_valid_s = 1'b1;
          emit_err_s   = pos_err_s;
        end else if (ref_pulse_s) begin
          emit_valid_s = 1'b1;
          emit_err_s   = max_pos_s;
        end else begin
          emit_valid_s = 1'b0;
        end
      end
      PD_FB_LEAD: begin
        if (ref_pulse_s) begin
          emit_valid_s = 1'b1;
          emit_err_s   = neg_err_s;
        end else if (fb_pulse_s) begin
          emit_valid_s = 1'b1;
          emit_err_s   = max_neg_s;
        end else begin
          emit_valid_s = 1'b0;
        end
      end
      default: begin
        emit_valid_s = 1'b0;
        emit_err_s   = {ERROR_WIDTH{1'b0}};
      end
    endcase
  end

  // Detector FSM, lag counter and registered error/valid outputs.
  always_ff @(posedge gen_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= PD_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      error_r <= {ERROR_WIDTH{1'b0}};
      valid_r <= 1'b0;
    end else begin
      valid_r <= emit_valid_s;
      if (emit_valid_s) begin
        error_r <= emit_err_s;
      end
      case (state_r)
        PD_IDLE: begin
          if (ref_pulse_s && !fb_pulse_s) begin
            state_r <= PD_REF_LEAD;
            cnt_r   <= {CNT_W{1'b0}};
          end else if (fb_pulse_s && !ref_pulse_s) begin
            state_r <= PD_FB_LEAD;
            cnt_r   <= {CNT_W{1'b0}};
          end
        end
        PD_REF_LEAD: begin
          if (ref_pulse_s) begin
            cnt_r <= {CNT_W{1'b0}};
          end else if (fb_pulse_s) begin
            state_r <= PD_IDLE;
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        PD_FB_LEAD: begin
          if (fb_pulse_s) begin
            cnt_r <= {CNT_W{1'b0}};
          end else if (ref_pulse_s) begin
            state_r <= PD_IDLE;
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        default: begin
          state_r <= PD_IDLE;
          cnt_r   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign pd_if.error_o = error_r;
  assign pd_if.valid_o = valid_r;

`ifdef PHASE_ERROR_LOCK_DETECT_EN
  localparam int unsigned LOCK_W = $clog2(LOCK_COUNT + 32'd1);

  logic [LOCK_W-1:0] lock_cnt_r;
  logic [LOCK_W-1:0] lock_cnt_inc_s;
  logic              in_lock_s;
  logic              lock_r;

  assign in_lock_s      = abs_err(int'(emit_err_s)) <= LOCK_THRESH;
  assign lock_cnt_inc_s = LOCK_W'(sat_inc(32'(lock_cnt_r), LOCK_COUNT));

  // Lock tracks the error being registered this edge, so it moves with valid.
  always_ff @(posedge gen_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lock_cnt_r <= {LOCK_W{1'b0}};
      lock_r     <= 1'b0;
    end else if (emit_valid_s) begin
      if (in_lock_s) begin
        lock_cnt_r <= lock_cnt_inc_s;
        lock_r     <= (32'(lock_cnt_inc_s) == LOCK_COUNT);
      end else begin
        lock_cnt_r <= {LOCK_W{1'b0}};
        lock_r     <= 1'b0;
      end
    end
  end

  assign pd_if.lock_o = lock_r;
`else
  assign pd_if.lock_o = 1'b0;
`endif

endmodule

// File: tb/tb_phase_error_detector.sv
// Scoreboard bench for phase_error_detector: an edge-time model predicts each
// error word and lock state, a monitor compares them as valid strobes appear.
module tb_phase_error_detector;

  localparam int EW     = 8;
  localparam int MAXV   = 127;
  localparam int LTH    = 2;
  localparam int LCNT   = 16;
  localparam int HIGH_T = 6;

  typedef struct {
    int err;
    bit lock;
  } exp_t;

  logic gen_clk = 1'b0;
  logic reset_n = 1'b0;
  logic ref_clk = 1'b0;
  logic fb_clk  = 1'b0;

  exp_t       exp_q[$];
  int         checks = 0;
  int         fails  = 0;
  int         lock_cnt_m = 0;
  bit [511:0] ref_ev;
  bit [511:0] fb_ev;

  phase_error_detector_if #(.ERROR_WIDTH(EW)) pd_if ();

  phase_error_detector #(
    .ERROR_WIDTH(EW), .SYNC_STAGES(2), .LOCK_THRESH(LTH), .LOCK_COUNT(LCNT)
  ) dut (
    .gen_clk_i(gen_clk),
    .reset_n_i(reset_n),
    .ref_clk_i(ref_clk),
    .fb_clk_i (fb_clk),
    .pd_if    (pd_if)
  );

  always #5 gen_clk = ~gen_clk;

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic bit level(input bit [511:0] v, input int i);
    bit l = 1'b0;
    for (int k = 0; k < HIGH_T; k++) begin
      if (i - k >= 0 && v[i-k]) l = 1'b1;
    end
    return l;
  endfunction

  task automatic check_eq(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic push_exp(input int e);
    exp_t x;
    int   a;
    a = (e < 0) ? -e : e;
    if (a <= LTH) lock_cnt_m = min_i(lock_cnt_m + 1, LCNT);
    else          lock_cnt_m = 0;
    x.err = e;
`ifdef PHASE_ERROR_LOCK_DETECT_EN
    x.lock = (lock_cnt_m == LCNT);
`else
    x.lock = 1'b0;
`endif
    exp_q.push_back(x);
  endtask

  // Walk the edge timeline: who leads, since when, and what each edge closes.
  task automatic model_scn(input int len);
    int leader = 0;
    int t0 = 0;
    bit r;
    bit f;
    for (int t = 0; t < len; t++) begin
      r = ref_ev[t];
      f = fb_ev[t];
      if (leader == 0) begin
        if (r && f)  push_exp(0);
        else if (r)  begin leader = 1; t0 = t; end
        else if (f)  begin leader = 2; t0 = t; end
      end else if (leader == 1) begin
        if (f) begin
          push_exp(min_i(t - t0, MAXV));
          if (r) t0 = t; else leader = 0;
        end else if (r) begin
          push_exp(MAXV);
          t0 = t;
        end
      end else begin
        if (r) begin
          push_exp(-min_i(t - t0, MAXV));
          if (f) t0 = t; else leader = 0;
        end else if (f) begin
          push_exp(-MAXV);
          t0 = t;
        end
      end
    end
  endtask

  task automatic drive_scn();
    int last = 0;
    for (int t = 0; t < 512; t++) begin
      if (ref_ev[t] || fb_ev[t]) last = t;
    end
    model_scn(last + 1);
    for (int i = 0; i < last + HIGH_T + 12; i++) begin
      @(negedge gen_clk);
      ref_clk = level(ref_ev, i);
      fb_clk  = level(fb_ev, i);
    end
  endtask

  task automatic pair(input int r_t, input int f_t);
    ref_ev = '0;
    fb_ev  = '0;
    ref_ev[r_t] = 1'b1;
    fb_ev[f_t]  = 1'b1;
    drive_scn();
  endtask

  task automatic triple(input bit ref_first, input int g1, input int g2);
    ref_ev = '0;
    fb_ev  = '0;
    if (ref_first) begin
      ref_ev[0] = 1'b1; ref_ev[g1] = 1'b1; fb_ev[g1+g2] = 1'b1;
    end else begin
      fb_ev[0] = 1'b1; fb_ev[g1] = 1'b1; ref_ev[g1+g2] = 1'b1;
    end
    drive_scn();
  endtask

  initial begin : monitor
    exp_t x;
    int   got;
    forever begin
      @(posedge gen_clk);
      #1;
      if (pd_if.valid_o === 1'b1) begin
        got = int'(pd_if.error_o);
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_valid: got error %0d, expected no strobe", got);
        end else begin
          x = exp_q.pop_front();
          check_eq("error_o", got, x.err);
          check_eq("lock_o", int'(pd_if.lock_o), int'(x.lock));
        end
      end
    end
  end

  initial begin : stimulus
    int d;
    int mode;
    int waited;

    repeat (3) @(negedge gen_clk);
    check_eq("reset_error", int'(pd_if.error_o), 0);
    check_eq("reset_valid", int'(pd_if.valid_o), 0);
    check_eq("reset_lock",  int'(pd_if.lock_o), 0);
    @(negedge gen_clk);
    reset_n = 1'b1;
    repeat (5) @(negedge gen_clk);

    pair(0, 10);
    pair(5, 0);
    pair(0, 0);
    triple(1'b1, 20, 20);
    ref_ev = '0; fb_ev = '0;
    ref_ev[0] = 1'b1; ref_ev[30] = 1'b1; fb_ev[30] = 1'b1; fb_ev[45] = 1'b1;
    drive_scn();
    pair(0, 200);
    triple(1'b0, 25, 140);

    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(0, 1) == 0) pair(0, 1);
      else                           pair(1, 0);
    end
    pair(0, 3);

    // Abort a measurement part-way through REF_LEAD.
    @(negedge gen_clk);
    ref_clk = 1'b1;
    repeat (7) @(negedge gen_clk);
    reset_n = 1'b0;
    #1;
    check_eq("midreset_error", int'(pd_if.error_o), 0);
    check_eq("midreset_valid", int'(pd_if.valid_o), 0);
    check_eq("midreset_lock",  int'(pd_if.lock_o), 0);
    lock_cnt_m = 0;
    repeat (3) @(negedge gen_clk);
    ref_clk = 1'b0;
    @(negedge gen_clk);
    reset_n = 1'b1;
    repeat (10) @(negedge gen_clk);
    pair(4, 0);
    pair(0, 4);

    for (int n = 0; n < 30; n++) begin
      mode = int'($urandom_range(0, 4));
      if (mode < 3) begin
        d = int'($urandom_range(0, 300)) - 150;
        if (d >= 0) pair(0, d);
        else        pair(-d, 0);
      end else begin
        triple(mode == 3, int'($urandom_range(12, 100)), int'($urandom_range(0, 140)));
      end
    end

    waited = 0;
    while (exp_q.size() != 0 && waited < 1000) begin
      @(negedge gen_clk);
      waited++;
    end
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d strobes still outstanding, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
